mult_pipe: RTL and testbench
============================

# mult_pipe

Parametrised, pipelined integer multiplier unit for the RV M-extension multiply ops (MUL, MULH, MULHSU, MULHU). It sits beside the ALU in EX. It is fed from the ID/EX operand and rd outputs, and drives a writeback port with a valid/ready handshake. It adds configurable XLEN and depth, backpressure, flush, and an rd-hazard query port for stall control. One shared signed (XLEN+1)x(XLEN+1) datapath serves all four op types.

## Interface
- XLEN, 32, operand/result width (≥8)
- STAGES, 3, pipeline depth = result latency in cycles (≥1)
- ADDR_W, 5, register address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill every in-flight op (branch mispredict/trap)
- in_valid  in  1  op presented
- in_ready  out  1  unit accepts the op this cycle
- op  in  2  00 MUL (low), 01 MULH (SxS high), 10 MULHSU (SxU high), 11 MULHU (UxU high)
- a, b  in  XLEN  rs1/rs2 data
- rd_addr  in  ADDR_W  destination register
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes the result
- out_data  out  XLEN  result
- out_rd  out  ADDR_W  destination of out_data
- hz_rd  in  ADDR_W  register being read by the instruction in ID
- hz_hit  out  1  hz_rd matches an in-flight destination
- inflight  out  clog2(STAGES+1)  number of valid entries in the pipe

## Operation
- Operand extension to XLEN+1 bits:
  - a is sign-extended for op 00/01/10 and zero-extended for 11.
  - b is sign-extended for op 00/01 and zero-extended for 10/11.
- Product is 2XLEN+2 bits, signed.
- Result selection:
  - op 00 selects product[XLEN-1:0].
  - All other ops select product[2XLEN-1:XLEN].
- Per-stage state: valid, op, rd, data. Stage 0 captures the full product; later stages shift it. Result selection is done at the last stage.
- advance = !valid[STAGES-1] | out_ready. The whole pipe shifts together on advance and holds on !advance. There is no bubble compaction.
- in_ready = advance & !flush.
- Accept = in_valid & in_ready. Stage 0 valid is set to accept & (rd_addr != 0).
  - An op with rd=0 is consumed (handshake completes) but never produces out_valid.
- If advance is high and no accept occurs, a bubble (valid=0) enters stage 0.
- out_valid = valid[STAGES-1]. out_data and out_rd come from the last stage.
  - out_data and out_rd are held stable while out_valid & !out_ready.
- flush:
  - Clears every valid bit at the next edge, including an un-consumed output.
  - No op is accepted in a flush cycle.
  - Data and rd registers are not required to clear.
- hz_hit = OR over i of (valid[i] & rd[i]==hz_rd) & (hz_rd != 0). It is combinational and includes the output stage.
- inflight = popcount(valid). It is combinational from the registers.
- Ordering: results leave in strict acceptance order.

## Timing
- Reset: all valid=0, out_valid=0, out_data=0, out_rd=0, hz_hit=0, inflight=0, in_ready=1 on the first cycle after reset.
- Latency:
  - An op accepted at edge N presents out_valid during the cycle after edge N+STAGES-1.
  - With STAGES=3 and no stalls, an op accepted at edge 0 is visible after edge 2 and is consumed at edge 3.
- Throughput: one op per cycle while out_ready=1.
- Stall: when out_ready=0 with out_valid=1, in_ready drops in the same cycle (combinational) and no stage changes.
- Simultaneous out handshake and new accept in one cycle is legal. The pipe shifts once.
- flush with rst: rst dominates. flush with out_ready: the output entry is discarded, and writeback must ignore out_valid in a flush cycle.
- Reset mid-operation: every in-flight op is lost. No out_valid occurs until new ops are accepted.

## Test plan
- Arithmetic, XLEN=32, STAGES=3:
  - MUL 7 x 0xFFFFFFFD -> out_data 0xFFFFFFEB, out_rd preserved, 3 cycles after accept.
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Backpressure: 4 back-to-back MULs (rd 1..4), out_ready low for 2 cycles once rd1 appears:
  - in_ready low for exactly those cycles.
  - Results appear in order 1..4, none duplicated or dropped.
  - inflight peaks at 3.
- Flush: 2 ops in flight, flush=1 with in_valid=1 the same cycle:
  - in_ready=0 in the flush cycle.
  - inflight=0 next cycle.
  - No out_valid is ever produced for either op or the presented op.
- rd=0 and hazard:
  - Accept a MUL with rd=0 -> in_ready=1, out_valid never set.
  - Accept rd=5, then sweep hz_rd -> hz_hit=1 only for hz_rd=5 until its handshake completes. hz_rd=0 never hits.
- Reset mid-operation: assert rst with 3 ops in flight -> next cycle out_valid=0, out_data=0, inflight=0. A fresh MUL 3x4 afterwards returns 12 after 3 cycles.
- Parameter sweep: STAGES=1 and XLEN=64, run random ops against a reference model -> exact match, latency equals STAGES.

Source files
------------

// File: rtl/mult_pipe.sv
// Pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU) with a valid/ready writeback port,
// flush, and an rd-hazard query. One signed (XLEN+1)x(XLEN+1) product serves every op.
module mult_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       op,
  input  logic [XLEN-1:0]                  a,
  input  logic [XLEN-1:0]                  b,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  out_data,
  output logic [ADDR_W-1:0]                out_rd,
  input  logic [ADDR_W-1:0]                hz_rd,
  output logic                             hz_hit,
  output logic [$clog2(STAGES+1)-1:0]      inflight
);

  localparam int unsigned PW   = 2 * XLEN + 2;
  localparam int unsigned CW   = $clog2(STAGES + 1);
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [PW-1:0]     prod_q [STAGES];
  logic [PW-1:0]     prod_d [STAGES];
  logic [1:0]        op_q   [STAGES];
  logic [1:0]        op_d   [STAGES];
  logic [ADDR_W-1:0] rd_q   [STAGES];
  logic [ADDR_W-1:0] rd_d   [STAGES];

  logic                 advance, accept;
  logic                 a_sx, b_sx;
  logic signed [PW-1:0] a_w, b_w, prod;
  logic [PW-1:0]        last_prod;

  // Operand extension: a is signed unless MULHU, b is signed only for MUL/MULH.
  always_comb begin
    a_sx = (op != 2'b11);
    b_sx = ~op[1];
    a_w  = {{(PW - XLEN){a_sx & a[XLEN-1]}}, a};
    b_w  = {{(PW - XLEN){b_sx & b[XLEN-1]}}, b};
    prod = a_w * b_w;
  end

  assign advance  = ~valid_q[LAST] | out_ready;
  assign in_ready = advance & ~flush;
  assign accept   = in_valid & in_ready;

  // Whole-pipe shift on advance; flush only kills valid bits.
  always_comb begin
    valid_d = valid_q;
    prod_d  = prod_q;
    op_d    = op_q;
    rd_d    = rd_q;
    if (advance) begin
      for (int i = 1; i < int'(STAGES); i++) begin
        valid_d[i] = valid_q[i-1];
        prod_d[i]  = prod_q[i-1];
        op_d[i]    = op_q[i-1];
        rd_d[i]    = rd_q[i-1];
      end
      valid_d[0] = accept & (rd_addr != '0);
      if (accept) begin
        prod_d[0] = prod;
        op_d[0]   = op;
        rd_d[0]   = rd_addr;
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        prod_q[i] <= '0;
        op_q[i]   <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      prod_q  <= prod_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  // Result selection happens at the output stage.
  always_comb begin
    last_prod = prod_q[LAST];
    out_valid = valid_q[LAST];
    out_rd    = rd_q[LAST];
    out_data  = (op_q[LAST] == 2'b00) ? last_prod[XLEN-1:0] : last_prod[2*XLEN-1:XLEN];
  end

  // Hazard query and occupancy, combinational off the stage registers.
  always_comb begin
    hz_hit   = 1'b0;
    inflight = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (valid_q[i] && (rd_q[i] == hz_rd)) hz_hit = 1'b1;
      inflight = inflight + CW'(valid_q[i]);
    end
    if (hz_rd == '0) hz_hit = 1'b0;
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: XLEN=32/STAGES=3 instance against a queue model,
// plus an XLEN=64/STAGES=1 instance checked op by op.
module tb_mult_pipe;

  localparam int STG = 3;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, hz_hit;
  logic [1:0]  op;
  logic [31:0] a, b, out_data;
  logic [4:0]  rd_addr, out_rd, hz_rd;
  logic [1:0]  inflight;

  logic        w_in_valid, w_in_ready, w_out_valid, w_hz_hit;
  logic [1:0]  w_op;
  logic [63:0] w_a, w_b, w_out_data;
  logic [4:0]  w_rd_addr, w_out_rd;
  logic [0:0]  w_inflight;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_pipe #(.XLEN(32), .STAGES(STG), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .rd_addr(rd_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .hz_rd(hz_rd), .hz_hit(hz_hit), .inflight(inflight)
  );

  mult_pipe #(.XLEN(64), .STAGES(1), .ADDR_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .op(w_op), .a(w_a), .b(w_b), .rd_addr(w_rd_addr), .out_valid(w_out_valid), .out_ready(1'b1),
    .out_data(w_out_data), .out_rd(w_out_rd), .hz_rd(5'd0), .hz_hit(w_hz_hit), .inflight(w_inflight)
  );

  // Reference: high word from the unsigned product, then sign corrections.
  function automatic logic [63:0] ref_mul(input logic [1:0] fop, input logic [63:0] fa,
                                          input logic [63:0] fb, input int xlen);
    logic [63:0]  mask, ua, ub, hiu;
    logic [127:0] p, sh;
    logic         an, bn;
    mask = (xlen >= 64) ? {64{1'b1}} : ((64'd1 << xlen) - 64'd1);
    ua   = fa & mask;
    ub   = fb & mask;
    p    = {64'd0, ua} * {64'd0, ub};
    sh   = p >> xlen;
    hiu  = sh[63:0] & mask;
    an   = ua[xlen-1];
    bn   = ub[xlen-1];
    case (fop)
      2'b00:   return p[63:0] & mask;
      2'b01:   return (hiu - (an ? ub : 64'd0) - (bn ? ua : 64'd0)) & mask;
      2'b10:   return (hiu - (an ? ub : 64'd0)) & mask;
      default: return hiu;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: each accepted op must see STG-1 advancing edges before it is visible.
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          left;
  } ent_t;

  ent_t mq[$];
  bit   live = 1'b0;
  bit   rec  = 1'b0;
  logic [4:0] got[$];

  always @(posedge clk) begin
    bit mvis;
    if (rst) begin
      mq.delete();
      live = 1'b1;
    end else begin
      mvis = (mq.size() > 0) && (mq[0].left == 0);
      if (flush) mq.delete();
      else if (!mvis || out_ready) begin
        if (mvis) void'(mq.pop_front());
        foreach (mq[i]) if (mq[i].left > 0) mq[i].left--;
        if (in_valid && rd_addr != 5'd0)
          mq.push_back('{data: 32'(ref_mul(op, 64'(a), 64'(b), 32)), rd: rd_addr, left: STG - 1});
      end
    end
  end

  always @(negedge clk) begin
    bit cvis, chz;
    if (live && !rst) begin
      cvis = (mq.size() > 0) && (mq[0].left == 0);
      chz  = 1'b0;
      foreach (mq[i]) if (mq[i].rd == hz_rd) chz = 1'b1;
      if (hz_rd == 5'd0) chz = 1'b0;
      check("cmp_out_valid", 64'(out_valid), 64'(cvis));
      check("cmp_in_ready", 64'(in_ready), 64'((!cvis || out_ready) && !flush));
      check("cmp_inflight", 64'(inflight), 64'(mq.size()));
      check("cmp_hz_hit", 64'(hz_hit), 64'(chz));
      if (cvis) begin
        check("cmp_out_data", 64'(out_data), 64'(mq[0].data));
        check("cmp_out_rd", 64'(out_rd), 64'(mq[0].rd));
      end
      if (rec && out_valid && out_ready && !flush) got.push_back(out_rd);
    end
  end

  task automatic arith(input string nm, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] r, input logic [31:0] exp);
    out_ready = 1'b1;
    op = o; a = x; b = y; rd_addr = r; in_valid = 1'b1;
    #1 check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    check({nm, "_early0"}, 64'(out_valid), 64'd0);
    cyc();
    check({nm, "_early1"}, 64'(out_valid), 64'd0);
    cyc();
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_data"}, 64'(out_data), 64'(exp));
    check({nm, "_rd"}, 64'(out_rd), 64'(r));
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_low, peak, seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
    rd_addr = '0; out_ready = 1'b1; hz_rd = 5'd3;
    w_in_valid = 1'b0; w_op = 2'b00; w_a = '0; w_b = '0; w_rd_addr = '0;
    cyc(); cyc();
    rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_hz_hit", 64'(hz_hit), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst64_out_valid", 64'(w_out_valid), 64'd0);
    check("rst64_out_data", w_out_data, 64'd0);

    check("model_mul", ref_mul(2'b00, 64'd7, 64'hFFFFFFFD, 32), 64'hFFFFFFEB);
    check("model_mulh", ref_mul(2'b01, 64'h80000000, 64'h80000000, 32), 64'h40000000);
    check("model_mulhu", ref_mul(2'b11, 64'hFFFFFFFF, 64'hFFFFFFFF, 32), 64'hFFFFFFFE);
    check("model_mulhsu", ref_mul(2'b10, 64'hFFFFFFFF, 64'hFFFFFFFF, 32), 64'hFFFFFFFF);

    arith("mul", 2'b00, 32'd7, 32'hFFFFFFFD, 5'd9, 32'hFFFFFFEB);
    arith("mulh", 2'b01, 32'h80000000, 32'h80000000, 5'd10, 32'h40000000);
    arith("mulhu", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFE);
    arith("mulhsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFF);
    arith("mulh_neg", 2'b01, 32'hFFFFFFFE, 32'd3, 5'd13, 32'hFFFFFFFF);

    // Backpressure: four MULs, two stall cycles once the first result shows.
    n_low = 0; peak = 0; seen = 2; rec = 1'b1; got.delete();
    for (int i = 1; i <= 4;) begin
      op = 2'b00; a = 32'(i); b = 32'd10; rd_addr = 5'(i); in_valid = 1'b1;
      if (out_valid && seen > 0) begin out_ready = 1'b0; seen--; end
      else out_ready = 1'b1;
      #1;
      if (in_ready) i++; else n_low++;
      if (int'(inflight) > peak) peak = int'(inflight);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && mq.size() > 0; k++) cyc();
    cyc();
    rec = 1'b0;
    check("bp_in_ready_low", 64'(n_low), 64'd2);
    check("bp_peak", 64'(peak), 64'd3);
    check("bp_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("bp_order", (i < got.size()) ? 64'(got[i]) : 64'hDEAD, 64'(i + 1));

    // Flush with two ops in flight and a third presented.
    op = 2'b00; a = 32'd5; b = 32'd6; rd_addr = 5'd7; in_valid = 1'b1;
    cyc();
    rd_addr = 5'd8;
    cyc();
    rd_addr = 5'd9; flush = 1'b1;
    #1 check("fl_in_ready", 64'(in_ready), 64'd0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_inflight", 64'(inflight), 64'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin if (out_valid) seen++; cyc(); end
    check("fl_no_out", 64'(seen), 64'd0);

    // rd=0 is consumed but never produces a result.
    op = 2'b00; a = 32'd2; b = 32'd2; rd_addr = 5'd0; in_valid = 1'b1;
    #1 check("rd0_in_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin if (out_valid) seen++; cyc(); end
    check("rd0_no_out", 64'(seen), 64'd0);

    // Hazard sweep while rd=5 is held in the output stage.
    op = 2'b00; a = 32'd1; b = 32'd1; rd_addr = 5'd5; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int h = 0; h < 32; h++) begin
      hz_rd = 5'(h);
      #1 check("hz_sweep", 64'(hz_hit), (h == 5) ? 64'd1 : 64'd0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    hz_rd = 5'd5;
    #1 check("hz_after", 64'(hz_hit), 64'd0);

    // Reset with three ops in flight.
    op = 2'b00; a = 32'd9; b = 32'd9; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin rd_addr = 5'(i); cyc(); end
    in_valid = 1'b0; rst = 1'b1;
    cyc();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_inflight", 64'(inflight), 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin if (out_valid) seen++; cyc(); end
    check("mid_rst_no_out", 64'(seen), 64'd0);
    arith("post_rst", 2'b00, 32'd3, 32'd4, 5'd6, 32'd12);

    // XLEN=64, STAGES=1: result visible one edge after accept.
    for (int n = 0; n < 24; n++) begin
      case (n)
        0: begin w_op = 2'b11; w_a = '1; w_b = '1; end
        1: begin w_op = 2'b01; w_a = 64'h8000000000000000; w_b = 64'h8000000000000000; end
        2: begin w_op = 2'b10; w_a = '1; w_b = '1; end
        default: begin
          w_op = 2'($urandom_range(0, 3));
          w_a  = {$urandom(), $urandom()};
          w_b  = {$urandom(), $urandom()};
        end
      endcase
      w_rd_addr = 5'($urandom_range(1, 31));
      w_in_valid = 1'b1;
      #1 check("x64_in_ready", 64'(w_in_ready), 64'd1);
      cyc();
      check("x64_valid", 64'(w_out_valid), 64'd1);
      check("x64_data", w_out_data, ref_mul(w_op, w_a, w_b, 64));
      check("x64_rd", 64'(w_out_rd), 64'(w_rd_addr));
      if (n == 0) check("x64_mulhu_lit", w_out_data, 64'hFFFFFFFFFFFFFFFE);
      if (n == 1) check("x64_mulh_lit", w_out_data, 64'h4000000000000000);
      if (n == 2) check("x64_mulhsu_lit", w_out_data, 64'hFFFFFFFFFFFFFFFF);
    end
    w_in_valid = 1'b0;
    cyc();
    check("x64_idle", 64'(w_out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
